// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio filter MAC scheduling block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scheduler state enum, default sample width, zero-frame predicate.
package audio_pkg;

  // Default sample width of the filter chain.
  localparam int DW_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_RUN_L   = 3'd2,
    ST_RUN_R   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ZACK    = 3'd5
  } sched_state_e;

  // A frame is silent only when both channels are exactly zero.
  function automatic logic is_zero_frame(input logic [DW_DEFAULT-1:0] l,
                                         input logic [DW_DEFAULT-1:0] r);
    return (l == '0) && (r == '0);
  endfunction

endpackage

// File: rtl/mac_scheduler_if.sv
// Bus between the scheduler and its surroundings: frame input plus MAC/history controls.
// Latency: n/a (wires only).
// Backpressure: none; frames offered while the scheduler is busy are dropped and flagged.
// slave: scheduler side (takes input_ready/dataL/dataR, drives controls and status).
// master: environment side (drives frames, observes controls and status).
interface mac_scheduler_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          input_ready;
  logic [DW-1:0] dataL;
  logic [DW-1:0] dataR;
  logic          hist_we;
  logic [AW-1:0] hist_waddr;
  logic [AW-1:0] hist_raddr;
  logic [AW-1:0] coef_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_ch;
  logic          out_ready;
  logic          out_zero;
  logic          sleeping;
  logic          overrun;

  modport slave (
    input  input_ready, dataL, dataR,
    output hist_we, hist_waddr, hist_raddr, coef_addr,
           mac_en, mac_clr, mac_ch, out_ready, out_zero, sleeping, overrun
  );

  modport master (
    output input_ready, dataL, dataR,
    input  hist_we, hist_waddr, hist_raddr, coef_addr,
           mac_en, mac_clr, mac_ch, out_ready, out_zero, sleeping, overrun
  );
endinterface

// File: rtl/zero_run_counter.sv
// Counts consecutive accepted silent frames, saturating; flags sleep at saturation.
// Latency: sleeping reflects an acceptance on the following cycle.
// Backpressure: none; only acts on accepted frames.
// Ports: Dclk, Clear (sync, active-high), accept, is_zero -> sleeping.
module zero_run_counter #(
  parameter int SLEEP_COUNT = 800
) (
  input  logic Dclk,
  input  logic Clear,
  input  logic accept,
  input  logic is_zero,
  output logic sleeping
);

  localparam int ZW = $clog2(SLEEP_COUNT + 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(SLEEP_COUNT);

  logic [ZW-1:0] zcnt_q, zcnt_d;

  always_comb begin
    zcnt_d = zcnt_q;
    if (accept) begin
      if (!is_zero) begin
        zcnt_d = '0;
      end else if (zcnt_q != ZMAX) begin
        zcnt_d = zcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Dclk) begin
    if (Clear) begin
      zcnt_q <= '0;
    end else begin
      zcnt_q <= zcnt_d;
    end
  end

  assign sleeping = (zcnt_q == ZMAX);

endmodule

// File: rtl/mac_scheduler.sv
// Sequences one TAPS-tap FIR pass per channel (left then right) over a shared MAC.
// Latency: out_ready 2*TAPS+2 cycles after input_ready; 1 cycle for a sleeping zero frame.
// Backpressure: frames accepted only in IDLE/DONE; others are dropped and set sticky overrun.
// Ports: Dclk, Clear (sync, active-high), bus (mac_scheduler_if.slave).
module mac_scheduler
  import audio_pkg::*;
#(
  parameter int TAPS        = 16,
  parameter int AW          = 4,
  parameter int DW          = audio_pkg::DW_DEFAULT,
  parameter int SLEEP_COUNT = 800
) (
  input  logic           Dclk,
  input  logic           Clear,
  mac_scheduler_if.slave bus
);

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          overrun_q, overrun_d;

  logic [DW-1:0] data_l, data_r;
  logic          can_accept;
  logic          accept;
  logic          is_zero;
  logic          sleeping;

  assign data_l     = bus.dataL;
  assign data_r     = bus.dataR;
  assign is_zero    = is_zero_frame(data_l, data_r);
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept     = bus.input_ready && can_accept;

  zero_run_counter #(
    .SLEEP_COUNT(SLEEP_COUNT)
  ) u_zero_run (
    .Dclk    (Dclk),
    .Clear   (Clear),
    .accept  (accept),
    .is_zero (is_zero),
    .sleeping(sleeping)
  );

  // Next-state logic. A frame offered outside IDLE/DONE changes nothing but overrun.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wptr_d    = wptr_q;
    overrun_d = overrun_q | (bus.input_ready & ~can_accept);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.input_ready) begin
          // sleeping is the pre-acceptance value: the frame that saturates zcnt still runs.
          state_d = (is_zero && sleeping) ? ST_ZACK : ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        k_d     = '0;
        state_d = ST_RUN_L;
      end
      ST_RUN_L: begin
        if (k_q == LAST_TAP) begin
          k_d     = '0;
          state_d = ST_RUN_R;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_RUN_R: begin
        if (k_q == LAST_TAP) begin
          k_d     = '0;
          wptr_d  = wptr_q + 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_ZACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from state, k and wptr.
  logic          hist_we, mac_en, mac_clr, mac_ch, out_ready, out_zero;
  logic [AW-1:0] hist_waddr, hist_raddr, coef_addr;

  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = '0;
    hist_raddr = '0;
    coef_addr  = '0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    mac_ch     = 1'b0;
    out_ready  = 1'b0;
    out_zero   = 1'b0;
    case (state_q)
      ST_CAPTURE: begin
        hist_we    = 1'b1;
        hist_waddr = wptr_q;
      end
      ST_RUN_L, ST_RUN_R: begin
        mac_en     = 1'b1;
        mac_clr    = (k_q == '0);
        mac_ch     = (state_q == ST_RUN_R);
        coef_addr  = k_q;
        // Newest sample sits at wptr; tap k reads k samples back, wrapping.
        hist_raddr = wptr_q - k_q;
      end
      ST_DONE: begin
        out_ready = 1'b1;
      end
      ST_ZACK: begin
        out_ready = 1'b1;
        out_zero  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Dclk) begin
    if (Clear) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      wptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wptr_q    <= wptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.hist_we    = hist_we;
  assign bus.hist_waddr = hist_waddr;
  assign bus.hist_raddr = hist_raddr;
  assign bus.coef_addr  = coef_addr;
  assign bus.mac_en     = mac_en;
  assign bus.mac_clr    = mac_clr;
  assign bus.mac_ch     = mac_ch;
  assign bus.out_ready  = out_ready;
  assign bus.out_zero   = out_zero;
  assign bus.sleeping   = sleeping;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Self-checking bench for mac_scheduler (TAPS=16, SLEEP_COUNT=20).
// Every cycle is compared against a frame-timeline model; directed checks cover key cycles.
// Stimulus: directed scenarios followed by randomized frames, silence runs and clears.
module tb_mac_scheduler;

  localparam int T  = 16;
  localparam int SC = 20;

  logic Dclk = 1'b0;
  logic Clear;

  mac_scheduler_if #(.DW(16), .AW(4)) bus ();

  mac_scheduler #(
    .TAPS(T), .AW(4), .DW(16), .SLEEP_COUNT(SC)
  ) dut (
    .Dclk (Dclk),
    .Clear(Clear),
    .bus  (bus)
  );

  always #5 Dclk = ~Dclk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int we_seen  = 0;
  int rdy_seen = 0;

  // Reference model: mp = cycles since the accepting edge of the running frame (-1 = none).
  int         mp    = -1;
  bit         mzack = 1'b0;
  logic [3:0] mwptr = 4'd0;
  int         mzcnt = 0;
  bit         movr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] obs();
    return {bus.hist_we, bus.hist_waddr, bus.hist_raddr, bus.coef_addr,
            bus.mac_en, bus.mac_clr, bus.mac_ch, bus.out_ready, bus.out_zero,
            bus.sleeping, bus.overrun};
  endfunction

  function automatic logic [19:0] model_out();
    logic       we, run, ch, clr, ordy;
    logic [3:0] wa, ra, ca;
    int         tap;
    we   = (mp == 1);
    wa   = we ? mwptr : 4'd0;
    run  = (mp >= 2) && (mp <= 2*T+1);
    tap  = run ? (mp - 2) % T : 0;
    ch   = run && (mp >= T + 2);
    ca   = 4'(tap);
    ra   = run ? 4'(mwptr - 4'(tap)) : 4'd0;
    clr  = run && (tap == 0);
    ordy = (mp == 2*T+2) || mzack;
    return {we, wa, ra, ca, run, clr, ch, ordy, mzack, (mzcnt == SC), movr};
  endfunction

  task automatic model_edge(input bit ir, input logic [15:0] l, input logic [15:0] r,
                            input bit clr);
    int oldp;
    bit can, zk;
    if (clr) begin
      mp = -1; mzack = 1'b0; mwptr = 4'd0; mzcnt = 0; movr = 1'b0;
    end else begin
      oldp = mp;
      zk   = mzack;
      can  = (oldp == -1 && !zk) || (oldp == 2*T+2);
      if (oldp == 2*T+1) mwptr = mwptr + 4'd1;
      mzack = 1'b0;
      mp = (oldp >= 1 && oldp <= 2*T+1) ? oldp + 1 : -1;
      if (ir) begin
        if (can) begin
          if (l == 0 && r == 0) begin
            if (mzcnt == SC) mzack = 1'b1;
            else mp = 1;
            if (mzcnt < SC) mzcnt++;
          end else begin
            mp = 1;
            mzcnt = 0;
          end
        end else begin
          movr = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, take the edge, compare all outputs 1 time unit later.
  task automatic step(input bit ir, input logic [15:0] l, input logic [15:0] r, input bit clr);
    bus.input_ready = ir;
    bus.dataL       = l;
    bus.dataR       = r;
    Clear           = clr;
    @(posedge Dclk);
    model_edge(ir, l, r, clr);
    #1;
    cyc++;
    if (bus.hist_we === 1'b1) we_seen++;
    if (bus.out_ready === 1'b1) rdy_seen++;
    check($sformatf("model@%0d", cyc), 32'(obs()), 32'(model_out()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic clear_step();
    step(1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  // Issue a frame and run to its DONE cycle (cycle 2T+2 after acceptance).
  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    step(1'b1, l, r, 1'b0);
    idle(2*T+1);
  endtask

  logic [15:0] rl, rr;
  int          w0, r0;
  bit          ir, zmode, cl;

  initial begin
    bus.input_ready = 1'b0;
    bus.dataL = '0;
    bus.dataR = '0;
    Clear = 1'b1;

    // Reset state
    clear_step();
    clear_step();
    check("reset_outputs", 32'(obs()), 32'h0);

    // Single frame timing
    idle(2);
    step(1'b1, 16'h1234, 16'h0001, 1'b0);                           // cycle 1
    check("s1_capture", 32'({bus.hist_we, bus.hist_waddr}), 32'h10);
    step(1'b0, 16'h0, 16'h0, 1'b0);                                 // cycle 2
    check("s1_clr_c2", 32'({bus.mac_en, bus.mac_clr, bus.mac_ch}), 32'b110);
    step(1'b0, 16'h0, 16'h0, 1'b0);                                 // cycle 3
    check("s1_raddr_c3", 32'(bus.hist_raddr), 32'd15);
    idle(15);                                                       // cycle 18
    check("s1_clr_c18", 32'({bus.mac_en, bus.mac_clr, bus.mac_ch}), 32'b111);
    idle(16);                                                       // cycle 34
    check("s1_done_c34", 32'({bus.out_ready, bus.out_zero}), 32'b10);
    step(1'b1, 16'h00AA, 16'h0BB0, 1'b0);
    check("s1_next_waddr", 32'({bus.hist_we, bus.hist_waddr}), 32'h11);
    idle(2*T+1);

    // Back-to-back frames, each issued in the previous DONE cycle
    clear_step();
    for (int f = 0; f < 17; f++) begin
      rl = 16'($urandom_range(1, 65535));
      rr = 16'($urandom);
      step(1'b1, rl, rr, 1'b0);
      check("b2b_capture", 32'(bus.hist_we), 32'd1);
      idle(2*T+1);
    end
    step(1'b1, 16'h0101, 16'h0202, 1'b0);
    check("b2b_wrap_waddr", 32'({bus.hist_we, bus.hist_waddr}), 32'h11);
    check("b2b_no_overrun", 32'(bus.overrun), 32'd0);
    idle(2*T+1);

    // Frame offered mid-run: dropped and flagged, running frame unaffected
    idle(1);
    w0 = we_seen; r0 = rdy_seen;
    step(1'b1, 16'h4321, 16'h1111, 1'b0);                           // cycle 1
    idle(9);                                                        // cycle 10
    step(1'b1, 16'hBEEF, 16'h0F0F, 1'b0);                           // cycle 11
    check("ovr_set", 32'(bus.overrun), 32'd1);
    idle(23);                                                       // cycle 34
    check("ovr_frame_done", 32'(bus.out_ready), 32'd1);
    idle(5);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    check("ovr_one_write", 32'(we_seen - w0), 32'd1);
    check("ovr_one_ready", 32'(rdy_seen - r0), 32'd1);

    // Sleep entry, zero acknowledge and wake
    clear_step();
    for (int f = 1; f <= SC; f++) begin
      step(1'b1, 16'h0, 16'h0, 1'b0);
      check("sleep_normal_pass", 32'(bus.hist_we), 32'd1);
      check("sleep_flag", 32'(bus.sleeping), (f == SC) ? 32'd1 : 32'd0);
      idle(2*T+1);
    end
    step(1'b1, 16'h0, 16'h0, 1'b0);
    check("zack_out", 32'({bus.out_ready, bus.out_zero, bus.mac_en, bus.hist_we}), 32'b1100);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    check("zack_after", 32'({bus.out_ready, bus.sleeping}), 32'b01);
    step(1'b1, 16'h0005, 16'h0000, 1'b0);
    check("wake_capture", 32'({bus.hist_we, bus.sleeping}), 32'b10);
    idle(2*T+1);
    check("wake_done", 32'({bus.out_ready, bus.out_zero}), 32'b10);

    // Clear in the middle of a frame
    idle(3);
    clear_step();
    r0 = rdy_seen;
    step(1'b1, 16'h7777, 16'h1234, 1'b0);                           // cycle 1
    idle(24);                                                       // cycle 25
    step(1'b0, 16'h0, 16'h0, 1'b1);
    check("clr_abort", 32'(obs()), 32'h0);
    idle(40);
    check("clr_no_ready", 32'(rdy_seen - r0), 32'd0);
    step(1'b1, 16'h0042, 16'h0000, 1'b0);
    check("clr_waddr", 32'({bus.hist_we, bus.hist_waddr}), 32'h10);
    idle(2*T+1);

    // Zero run broken by a nonzero frame
    clear_step();
    for (int f = 0; f < 18; f++) frame(16'h0, 16'h0);
    frame(16'h0000, 16'h8000);
    check("zrun_cleared", 32'(bus.sleeping), 32'd0);
    for (int f = 0; f < 19; f++) frame(16'h0, 16'h0);
    check("zrun_no_sleep", 32'(bus.sleeping), 32'd0);

    // Randomized traffic: alternating silence-heavy and mixed phases
    clear_step();
    for (int i = 0; i < 4000; i++) begin
      zmode = ((i / 1000) % 2) == 0;
      ir    = ($urandom_range(0, 12) == 0);
      cl    = ($urandom_range(0, 799) == 0);
      if (zmode || $urandom_range(0, 3) == 0) begin
        rl = 16'h0; rr = 16'h0;
      end else begin
        rl = 16'($urandom); rr = 16'($urandom);
      end
      step(ir, rl, rr, cl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
